// File: rtl/vga_sync_to_count.sv
// Recovers column/row counters from an upstream Hsync/Vsync pair; Vsync rise realigns to (0,0).
// Optional frame lock qualifier compiled in with `define VGA_SYNC_LOCK_CHECK_EN.
module vga_sync_to_count #(
    parameter int TOTAL_COLS  = 800,
    parameter int TOTAL_ROWS  = 525,
    parameter int COUNT_WIDTH = 10,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   Hsync_i,
    input  logic                   Vsync_i,
    output logic                   Hsync_o,
    output logic                   Vsync_o,
    output logic [COUNT_WIDTH-1:0] col_count_o,
    output logic [COUNT_WIDTH-1:0] row_count_o,
    output logic                   frame_start_o,
    output logic                   locked_o,
    output logic                   err_o
);

    localparam logic [COUNT_WIDTH-1:0] LAST_COL  = COUNT_WIDTH'(TOTAL_COLS - 1);
    localparam logic [COUNT_WIDTH-1:0] LAST_ROW  = COUNT_WIDTH'(TOTAL_ROWS - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

    // Reject counter widths that cannot hold the last column/row.
    if ((COUNT_WIDTH < $clog2(TOTAL_COLS)) || (COUNT_WIDTH < $clog2(TOTAL_ROWS)) ||
        (LOCK_FRAMES < 32'sd1)) begin : g_bad_params
        $error("vga_sync_to_count: illegal parameter combination");
    end

    logic                   hsync_q;
    logic                   vsync_q;
    logic [COUNT_WIDTH-1:0] col_q;
    logic [COUNT_WIDTH-1:0] col_d;
    logic [COUNT_WIDTH-1:0] row_q;
    logic [COUNT_WIDTH-1:0] row_d;
    logic                   frame_start_q;
    logic                   frame_start_d;
    logic                   vsync_rise_s;
    logic                   natural_wrap_s;

    assign vsync_rise_s   = Vsync_i & ~vsync_q;
    assign natural_wrap_s = (col_q == LAST_COL) && (row_q == LAST_ROW);

    // Counter next state: Vsync rise snaps to origin, otherwise raster free-run.
    always_comb begin
        col_d         = col_q;
        row_d         = row_q;
        frame_start_d = 1'b0;
        if (vsync_rise_s) begin
            col_d         = '0;
            row_d         = '0;
            frame_start_d = 1'b1;
        end else if (col_q == LAST_COL) begin
            col_d = '0;
            if (natural_wrap_s) begin
                row_d = '0;
            end else begin
                row_d = row_q + COUNT_ONE;
            end
        end else begin
            col_d = col_q + COUNT_ONE;
        end
    end

    // Sync delay line and counter registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            col_q         <= '0;
            row_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= Hsync_i;
            vsync_q       <= Vsync_i;
            col_q         <= col_d;
            row_q         <= row_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign Hsync_o       = hsync_q;
    assign Vsync_o       = vsync_q;
    assign col_count_o   = col_q;
    assign row_count_o   = row_q;
    assign frame_start_o = frame_start_q;

`ifdef VGA_SYNC_LOCK_CHECK_EN
    localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);
    localparam logic [GOOD_W-1:0] LAST_GOOD = GOOD_W'(LOCK_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_CHECK    = 2'd1,
        ST_LOCKED   = 2'd2
    } lock_state_t;

    lock_state_t       state_q;
    lock_state_t       state_d;
    logic [GOOD_W-1:0] good_cnt_q;
    logic [GOOD_W-1:0] good_cnt_d;
    logic              locked_q;
    logic              locked_d;
    logic              err_q;
    logic              err_d;
    logic              good_s;
    logic              bad_s;

    // Matching events are good; a lone rise or lone wrap is a timing error.
    assign good_s = vsync_rise_s & natural_wrap_s;
    assign bad_s  = vsync_rise_s ^ natural_wrap_s;

    // Lock state machine next state and error pulse.
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        err_d      = 1'b0;
        case (state_q)
            ST_UNLOCKED: begin
                if (vsync_rise_s) begin
                    state_d    = ST_CHECK;
                    good_cnt_d = '0;
                end else begin
                    state_d = ST_UNLOCKED;
                end
            end
            ST_CHECK: begin
                if (good_s) begin
                    good_cnt_d = good_cnt_q + GOOD_W'(1);
                    if (good_cnt_q == LAST_GOOD) begin
                        state_d = ST_LOCKED;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end else if (bad_s) begin
                    good_cnt_d = '0;
                    err_d      = 1'b1;
                end else begin
                    state_d = ST_CHECK;
                end
            end
            ST_LOCKED: begin
                if (bad_s) begin
                    state_d    = ST_CHECK;
                    good_cnt_d = '0;
                    err_d      = 1'b1;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d    = ST_UNLOCKED;
                good_cnt_d = '0;
            end
        endcase
        locked_d = (state_d == ST_LOCKED);
    end

    // Lock state registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_UNLOCKED;
            good_cnt_q <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
        end
    end

    assign locked_o = locked_q;
    assign err_o    = err_q;
`else
    assign locked_o = 1'b0;
    assign err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_to_count.sv
// Randomized bench for vga_sync_to_count on a reduced 12x8 raster, checked against
// a frame-position / good-frame-streak reference model.
module tb_vga_sync_to_count;

    localparam int TC    = 12;
    localparam int TR    = 8;
    localparam int AC    = 8;
    localparam int AR    = 5;
    localparam int CW    = 4;
    localparam int LF    = 2;
    localparam int FRAME = TC * TR;
`ifdef VGA_SYNC_LOCK_CHECK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          Hsync_i;
    logic          Vsync_i;
    logic          Hsync_o;
    logic          Vsync_o;
    logic [CW-1:0] col_count_o;
    logic [CW-1:0] row_count_o;
    logic          frame_start_o;
    logic          locked_o;
    logic          err_o;

    int errors = 0;
    int checks = 0;

    // upstream raster position
    int u_row = 0;
    int u_col = 0;

    // reference model: cycles since anchor, previous Vsync, lock streak
    int m_pos;
    bit m_prev_v, m_seen, m_locked, m_err, m_fs, m_hs, m_vs;
    int m_streak;

    vga_sync_to_count #(
        .TOTAL_COLS (TC),
        .TOTAL_ROWS (TR),
        .COUNT_WIDTH(CW),
        .LOCK_FRAMES(LF)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .Hsync_i      (Hsync_i),
        .Vsync_i      (Vsync_i),
        .Hsync_o      (Hsync_o),
        .Vsync_o      (Vsync_o),
        .col_count_o  (col_count_o),
        .row_count_o  (row_count_o),
        .frame_start_o(frame_start_o),
        .locked_o     (locked_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pos = 0; m_prev_v = 1'b0; m_seen = 1'b0; m_locked = 1'b0; m_err = 1'b0;
        m_fs = 1'b0; m_hs = 1'b0; m_vs = 1'b0; m_streak = 0;
    endtask

    // One clock: drive at negedge, advance model at posedge, compare 1 time unit later.
    task automatic tick(input logic rn, input logic h, input logic v);
        bit rise, wrap;
        int ec, er;
        @(negedge clk);
        rst_n = rn; Hsync_i = h; Vsync_i = v;
        @(posedge clk);
        if (rn) begin
            rise  = v && !m_prev_v;
            wrap  = (m_pos % FRAME) == FRAME - 1;
            m_err = 1'b0;
            if (LOCK_EN && (rise || wrap)) begin
                if (!m_seen) begin
                    if (rise) begin
                        m_seen = 1'b1; m_streak = 0;
                    end
                end else if (rise && wrap) begin
                    m_streak++;
                    if (m_streak >= LF) m_locked = 1'b1;
                end else begin
                    m_err = 1'b1; m_streak = 0; m_locked = 1'b0;
                end
            end
            m_pos    = rise ? 0 : m_pos + 1;
            m_fs     = rise; m_hs = h; m_vs = v; m_prev_v = v;
        end else begin
            model_reset();
        end
        #1;
        ec = m_pos % TC;
        er = (m_pos / TC) % TR;
        checks++; if (col_count_o !== CW'(ec)) begin errors++; $display("FAIL col_count: got %0d expected %0d at %0t", col_count_o, ec, $time); end
        checks++; if (row_count_o !== CW'(er)) begin errors++; $display("FAIL row_count: got %0d expected %0d at %0t", row_count_o, er, $time); end
        checks++; if (Hsync_o !== m_hs) begin errors++; $display("FAIL hsync_o: got %b expected %b at %0t", Hsync_o, m_hs, $time); end
        checks++; if (Vsync_o !== m_vs) begin errors++; $display("FAIL vsync_o: got %b expected %b at %0t", Vsync_o, m_vs, $time); end
        checks++; if (frame_start_o !== m_fs) begin errors++; $display("FAIL frame_start: got %b expected %b at %0t", frame_start_o, m_fs, $time); end
        checks++; if (locked_o !== m_locked) begin errors++; $display("FAIL locked: got %b expected %b at %0t", locked_o, m_locked, $time); end
        checks++; if (err_o !== m_err) begin errors++; $display("FAIL err: got %b expected %b at %0t", err_o, m_err, $time); end
    endtask

    task automatic gen(input logic rn, input bit suppress);
        tick(rn, u_col < AC, !suppress && (u_row < AR));
        u_col++;
        if (u_col == TC) begin
            u_col = 0;
            u_row = (u_row + 1) % TR;
        end
    endtask

    task automatic run_to_origin();
        for (int i = 0; i < FRAME && !(u_row == 0 && u_col == 0); i++) gen(1'b1, 1'b0);
    endtask

    task automatic run_clean(input int n);
        for (int i = 0; i < n; i++) gen(1'b1, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; Hsync_i = 1'b0; Vsync_i = 1'b0;
        model_reset();
        #2;
        checks++; if ({Hsync_o, Vsync_o, frame_start_o, locked_o, err_o} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {Hsync_o, Vsync_o, frame_start_o, locked_o, err_o}); end
        checks++; if ({col_count_o, row_count_o} !== 8'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", row_count_o, col_count_o); end
        for (int i = 0; i < 10; i++) tick(1'b0, 1'($urandom), 1'($urandom));
        u_row = $urandom_range(TR - 1, AR);
        u_col = $urandom_range(TC - 1, 0);
        gen(1'b1, 1'b0);
        checks++; if (col_count_o !== 4'd1) begin errors++; $display("FAIL release_col: got %0d expected 1", col_count_o); end
        run_to_origin();
        checks++; if (frame_start_o !== 1'b0) begin errors++; $display("FAIL no_frame_start_before_rise: got %b expected 0", frame_start_o); end
    endtask

    task automatic test_clean_frames();
        int max_col, max_row;
        max_col = 0; max_row = 0;
        gen(1'b1, 1'b0);
        checks++; if ({Vsync_o, frame_start_o, col_count_o, row_count_o} !== {1'b1, 1'b1, 8'd0}) begin errors++; $display("FAIL first_rise: got vs=%b fs=%b %0d/%0d expected 1 1 0/0", Vsync_o, frame_start_o, row_count_o, col_count_o); end
        for (int i = 0; i < FRAME - 1; i++) begin
            gen(1'b1, 1'b0);
            if (int'(col_count_o) > max_col) max_col = int'(col_count_o);
            if (int'(row_count_o) > max_row) max_row = int'(row_count_o);
        end
        checks++; if (max_col !== TC - 1) begin errors++; $display("FAIL max_col: got %0d expected %0d", max_col, TC - 1); end
        checks++; if (max_row !== TR - 1) begin errors++; $display("FAIL max_row: got %0d expected %0d", max_row, TR - 1); end
        gen(1'b1, 1'b0);
        checks++; if (locked_o !== 1'b0) begin errors++; $display("FAIL frame2_locked: got %b expected 0", locked_o); end
        run_clean(FRAME - 1);
        gen(1'b1, 1'b0);
        checks++; if (locked_o !== LOCK_EN) begin errors++; $display("FAIL frame3_locked: got %b expected %b", locked_o, LOCK_EN); end
    endtask

    task automatic test_early_vsync();
        int k;
        k = $urandom_range(3, 1);
        for (int i = 0; i < FRAME && !(u_row == TR - k && u_col == 0); i++) gen(1'b1, 1'b0);
        u_row = 0; u_col = 0;
        gen(1'b1, 1'b0);
        checks++; if (err_o !== LOCK_EN) begin errors++; $display("FAIL early_err: got %b expected %b", err_o, LOCK_EN); end
        checks++; if ({locked_o, frame_start_o, col_count_o, row_count_o} !== {1'b0, 1'b1, 8'd0}) begin errors++; $display("FAIL early_snap: got lk=%b fs=%b %0d/%0d expected 0 1 0/0", locked_o, frame_start_o, row_count_o, col_count_o); end
        gen(1'b1, 1'b0);
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL early_err_pulse: got %b expected 0", err_o); end
        run_clean(FRAME - 2);
        gen(1'b1, 1'b0);
        checks++; if (locked_o !== 1'b0) begin errors++; $display("FAIL early_relock1: got %b expected 0", locked_o); end
        run_clean(FRAME - 1);
        gen(1'b1, 1'b0);
        checks++; if (locked_o !== LOCK_EN) begin errors++; $display("FAIL early_relock2: got %b expected %b", locked_o, LOCK_EN); end
    endtask

    task automatic test_missing_vsync();
        run_to_origin();
        gen(1'b1, 1'b1);
        checks++; if (err_o !== LOCK_EN) begin errors++; $display("FAIL missing_err: got %b expected %b", err_o, LOCK_EN); end
        checks++; if ({locked_o, frame_start_o, col_count_o, row_count_o} !== {1'b0, 1'b0, 8'd0}) begin errors++; $display("FAIL missing_wrap: got lk=%b fs=%b %0d/%0d expected 0 0 0/0", locked_o, frame_start_o, row_count_o, col_count_o); end
        for (int i = 0; i < FRAME - 1; i++) gen(1'b1, 1'b1);
        gen(1'b1, 1'b0);
        checks++; if ({frame_start_o, err_o, locked_o} !== 3'b100) begin errors++; $display("FAIL missing_return: got fs/err/lk=%b expected 100", {frame_start_o, err_o, locked_o}); end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < FRAME && !(u_row == AR + 1 && u_col == TC / 2); i++) gen(1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if ({Hsync_o, Vsync_o, frame_start_o, locked_o, err_o, col_count_o, row_count_o} !== 13'd0) begin errors++; $display("FAIL async_reset: got %b expected all zero", {Hsync_o, Vsync_o, frame_start_o, locked_o, err_o, col_count_o, row_count_o}); end
        for (int i = 0; i < 3; i++) gen(1'b0, 1'b0);
        run_to_origin();
        gen(1'b1, 1'b0);
        run_clean(FRAME - 1);
        gen(1'b1, 1'b0);
        checks++; if (locked_o !== 1'b0) begin errors++; $display("FAIL rst_relock_early: got %b expected 0", locked_o); end
        run_clean(FRAME - 1);
        gen(1'b1, 1'b0);
        checks++; if (locked_o !== LOCK_EN) begin errors++; $display("FAIL rst_relock: got %b expected %b", locked_o, LOCK_EN); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(59, 0) == 0) begin
                u_row = $urandom_range(TR - 1, 0);
                u_col = $urandom_range(TC - 1, 0);
            end
            gen(($urandom_range(299, 0) != 0), ($urandom_range(39, 0) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_clean_frames();
        test_early_vsync();
        test_missing_vsync();
        test_reset_mid_frame();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
